// File: rtl/dffsr_pipe_pkg.sv
// Shared constants and helpers for the dffsr_pipe elastic register pipeline.
// DFFSR_PIPE_CLK2Q_DELAY_EN selects the simulation-only clock-to-Q delay model.
`timescale 1ns/1ps
package dffsr_pipe_pkg;

  // Matches the library DFF clock-to-Q figure, in ns.
  localparam int CLK2Q_DELAY_NS = 6;

  // Bits needed to represent 0..depth valid stages.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffsr_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// With DFFSR_PIPE_CLK2Q_DELAY_EN defined, clocked updates carry the library clock-to-Q delay.
`timescale 1ns/1ps
module dffsr_pipe_stage
  import dffsr_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             leave_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             valid_nxt_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush drops the word but leaves the data register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (leave_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
`ifdef DFFSR_PIPE_CLK2Q_DELAY_EN
      valid_q <= #(CLK2Q_DELAY_NS) valid_d;
      data_q  <= #(CLK2Q_DELAY_NS) data_d;
`else
      valid_q <= valid_d;
      data_q  <= data_d;
`endif
    end
  end

  assign valid_o     = valid_q;
  assign valid_nxt_o = valid_d;
  assign data_o      = data_q;

endmodule

// File: rtl/dffsr_pipe.sv
// Elastic valid/ready register pipeline of DEPTH stages with bubble collapsing,
// synchronous flush and occupancy count. Optional macro: DFFSR_PIPE_CLK2Q_DELAY_EN.
`timescale 1ns/1ps
module dffsr_pipe
  import dffsr_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CNT_W   = count_width(DEPTH)
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // A stage leaves when its successor is empty or leaving too; resolved tail to head.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~flush & (~v[0] | adv[0]);

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1] & ~flush;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = in_data;
      end else begin : g_body
        assign stage_in = d[gi-1];
      end

      dffsr_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk         (C),
        .rst_n       (R),
        .flush_i     (flush),
        .load_i      (load[gi]),
        .leave_i     (adv[gi]),
        .data_i      (stage_in),
        .valid_o     (v[gi]),
        .valid_nxt_o (v_nxt[gi]),
        .data_o      (d[gi])
      );
    end
  endgenerate

  // Occupancy is registered from the next-state valid bits so it tracks the stages.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CNT_W'(v_nxt[k]);
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_dffsr_pipe.sv
// Scoreboard bench for dffsr_pipe (WIDTH=8, DEPTH=3, RST_VAL=8'hA5).
`timescale 1ns/1ps
module tb_dffsr_pipe;

  logic       C;
  logic       R;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [1:0] count;

  typedef struct {
    logic [7:0] d;
    int         t;
  } item_t;

  item_t      sb[$];
  item_t      it;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic       irdy_s, ov_s;
  logic [7:0] od_s;
  logic [1:0] cnt_s;

  dffsr_pipe #(
    .WIDTH   (8),
    .DEPTH   (3),
    .RST_VAL (8'hA5)
  ) dut (
    .C         (C),
    .R         (R),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial begin
    C = 1'b0;
    forever #10 C = ~C;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Drive inputs at the falling edge, sample settled outputs 1 ns later.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    @(negedge C);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    irdy_s = in_ready;
    ov_s   = out_valid;
    od_s   = out_data;
    cnt_s  = count;
    cyc++;
  endtask

  task automatic test_reset();
    R = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h33, 1'b1, 1'b0);
      checks += 4;
      if (ov_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov_s); end
      if (od_s !== 8'hA5) begin errors++; $display("FAIL reset_out_data got=%h exp=a5", od_s); end
      if (cnt_s !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_s); end
      if (irdy_s !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", irdy_s); end
    end
    step(1'b1, 8'h33, 1'b1, 1'b1);
    checks++;
    if (irdy_s !== 1'b0) begin errors++; $display("FAIL reset_flush_in_ready got=%b exp=0", irdy_s); end
    R = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 8'h11, 1'b1, 1'b0);
      if (i == 1 || i == 2) begin
        checks++;
        if (ov_s !== 1'b0) begin errors++; $display("FAIL reset_early_valid step=%0d got=%b exp=0", i, ov_s); end
      end
      if (i == 3) begin
        checks++;
        if (ov_s !== 1'b1) begin errors++; $display("FAIL reset_first_word_valid got=%b exp=1", ov_s); end
      end
      if (ov_s && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL reset_sb unexpected out_data=%h", od_s);
        end else begin
          it = sb.pop_front();
          $display("out data=%h latency=%0d", od_s, cyc - it.t);
          if (od_s !== it.d || cyc - it.t != 3) begin
            errors++; $display("FAIL reset_sb got=%h lat=%0d exp=%h lat=3", od_s, cyc - it.t, it.d);
          end
        end
      end
      if (in_valid && irdy_s) sb.push_back('{in_data, cyc});
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 13; i++) begin
      step(i < 10, 8'(i + 1), 1'b1, 1'b0);
      checks++;
      if (ov_s !== (i >= 3)) begin errors++; $display("FAIL stream_gap step=%0d got=%b exp=%b", i, ov_s, i >= 3); end
      if (i < 10) begin
        checks++;
        if (irdy_s !== 1'b1) begin errors++; $display("FAIL stream_in_ready step=%0d got=%b exp=1", i, irdy_s); end
      end
      if (ov_s && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_sb unexpected out_data=%h", od_s);
        end else begin
          it = sb.pop_front();
          $display("out data=%h latency=%0d", od_s, cyc - it.t);
          if (od_s !== it.d || cyc - it.t != 3) begin
            errors++; $display("FAIL stream_sb got=%h lat=%0d exp=%h lat=3", od_s, cyc - it.t, it.d);
          end
        end
      end
      if (in_valid && irdy_s) sb.push_back('{in_data, cyc});
    end
  endtask

  task automatic test_backpressure();
    int  idx;
    bit  done;
    idx  = 0;
    done = 1'b0;
    for (int s = 0; s < 20 && !done; s++) begin
      step(idx < 4, 8'(idx + 1), s >= 4, 1'b0);
      if (s < 3) begin
        checks++;
        if (irdy_s !== 1'b1) begin errors++; $display("FAIL bp_fill_in_ready step=%0d got=%b exp=1", s, irdy_s); end
      end
      if (s == 3) begin
        checks += 2;
        if (irdy_s !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b exp=0", irdy_s); end
        if (cnt_s !== 2'd3) begin errors++; $display("FAIL bp_full_count got=%0d exp=3", cnt_s); end
      end
      if (ov_s && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_sb unexpected out_data=%h", od_s);
        end else begin
          it = sb.pop_front();
          $display("out data=%h", od_s);
          if (od_s !== it.d) begin errors++; $display("FAIL bp_sb got=%h exp=%h", od_s, it.d); end
        end
      end
      if (in_valid && irdy_s) begin
        sb.push_back('{in_data, cyc});
        idx++;
      end
      done = (idx == 4) && (sb.size() == 0);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL bp_drain_timeout accepted=%0d pending=%0d exp=4/0", idx, sb.size()); end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      if (in_valid && irdy_s) sb.push_back('{in_data, cyc});
    end
    for (int i = 0; i < 8; i++) begin
      step(i < 5, 8'(8'hB0 + i), 1'b1, 1'b0);
      if (i < 5) begin
        checks += 3;
        if (cnt_s !== 2'd3) begin errors++; $display("FAIL full_count step=%0d got=%0d exp=3", i, cnt_s); end
        if (irdy_s !== 1'b1) begin errors++; $display("FAIL full_in_ready step=%0d got=%b exp=1", i, irdy_s); end
        if (ov_s !== 1'b1) begin errors++; $display("FAIL full_out_valid step=%0d got=%b exp=1", i, ov_s); end
      end
      if (ov_s && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL full_sb unexpected out_data=%h", od_s);
        end else begin
          it = sb.pop_front();
          $display("out data=%h", od_s);
          if (od_s !== it.d) begin errors++; $display("FAIL full_sb got=%h exp=%h", od_s, it.d); end
        end
      end
      if (in_valid && irdy_s) sb.push_back('{in_data, cyc});
    end
  endtask

  task automatic test_flush();
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b1);
    checks += 2;
    if (irdy_s !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", irdy_s); end
    if (cnt_s !== 2'd2) begin errors++; $display("FAIL flush_pre_count got=%0d exp=2", cnt_s); end
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 8'hD0, 1'b1, 1'b0);
      if (i == 0) begin
        checks += 2;
        if (cnt_s !== 2'd0) begin errors++; $display("FAIL flush_post_count got=%0d exp=0", cnt_s); end
        if (ov_s !== 1'b0) begin errors++; $display("FAIL flush_post_valid got=%b exp=0", ov_s); end
      end
      if (ov_s && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL flush_sb unexpected out_data=%h", od_s);
        end else begin
          it = sb.pop_front();
          $display("out data=%h latency=%0d", od_s, cyc - it.t);
          if (od_s !== it.d || cyc - it.t != 3) begin
            errors++; $display("FAIL flush_sb got=%h lat=%0d exp=%h lat=3", od_s, cyc - it.t, it.d);
          end
        end
      end
      if (in_valid && irdy_s) sb.push_back('{in_data, cyc});
    end
  endtask

`ifdef DFFSR_PIPE_CLK2Q_DELAY_EN
  task automatic test_clk2q();
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge C);
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clk2q_early_valid got=%b exp=0", out_valid); end
    if (out_data !== 8'hD0) begin errors++; $display("FAIL clk2q_early_data got=%h exp=d0", out_data); end
    #6;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL clk2q_late_valid got=%b exp=1", out_valid); end
    if (out_data !== 8'h5A) begin errors++; $display("FAIL clk2q_late_data got=%h exp=5a", out_data); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_midreset();
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks += 2;
    if (cnt_s !== 2'd2) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=2", cnt_s); end
    if (ov_s !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", ov_s); end
    #2;
    R = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    if (count !== 2'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
    if (out_data !== 8'hA5) begin errors++; $display("FAIL midrst_data got=%h exp=a5", out_data); end
    sb.delete();
    @(negedge C);
    R = 1'b1;
  endtask

  initial begin
    R         = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_passthrough();
    test_flush();
`ifdef DFFSR_PIPE_CLK2Q_DELAY_EN
    test_clk2q();
`endif
    test_midreset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dffsr_pipe.md
Name: dffsr_pipe

Overview:
- Parametrised elastic register pipeline; successor to the single-bit DFF/DFFSR cells.
- Generalised in width (WIDTH bits) and depth (DEPTH stages), with a programmable reset value.
- Adds a valid/ready handshake with bubble collapsing, a synchronous flush and an occupancy count.
- Used as a timing/retiming stage between datapath blocks built from the cell library.

Parameters:
- WIDTH, 8, data bits per stage
- DEPTH, 3, number of register stages (>=1)
- RST_VAL, 0, value loaded into every stage data register on reset (WIDTH bits)

Ports:
- C  input  1  clock, rising-edge
- R  input  1  asynchronous reset, active-low (R=0 resets)
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  last stage data
- flush  input  1  synchronous clear of all valid bits
- count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (R=0, asynchronous, independent of C):
  - all stage valid bits 0
  - all stage data = RST_VAL
  - out_valid=0, out_data=RST_VAL, count=0
  - in_ready is combinational: reads 1 during reset only if flush=0
- Stage k (0..DEPTH-1) holds v[k], d[k]. Stage DEPTH-1 drives out_*.
- Advance rules:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready
  - adv[k] = v[k] & (~v[k+1] | adv[k+1])
  - Empty stages are filled by the stage behind them, so bubbles collapse.
- in_ready = ~flush & (~v[0] | adv[0]). Combinational; may depend on out_ready through the chain.
- Transfer in: in_valid & in_ready → d[0] <= in_data, v[0] <= 1.
- A stage that is neither loaded nor left keeps its data and valid bit unchanged. Data never changes while v=1 and not advancing.
- Latency: accepted word appears on out_valid exactly DEPTH cycles later when never stalled.
- Throughput: 1 word/cycle sustained with out_ready=1.
- Backpressure: with out_ready=0 the pipeline fills to DEPTH words, then in_ready=0. No word is lost or duplicated.
- Simultaneous transfer in and out when full: allowed; count stays at DEPTH.
- flush=1:
  - all v <= 0 at the next edge
  - in_ready=0, so no input is accepted that cycle
  - data registers are unchanged
  - out_valid remains as registered until the edge
- count = number of v bits set. Registered; updated every edge, and by reset.
- Reset asserted mid-operation: all words are discarded immediately, with no clock required.
- Reset deassertion is taken synchronously to C by the integrating block.

Optional Feature:
- Macro DFFSR_PIPE_CLK2Q_DELAY_EN.
- Defined: every stage register update (valid and data) uses a #6 ns clock-to-Q delay, matching the library DFF timing model. Asynchronous reset still clears with no delay. For simulation only.
- Undefined: zero-delay nonblocking updates; synthesizable; identical cycle behaviour.

Decomposition:
- Shared package holds:
  - the clock-to-Q delay constant (6 ns)
  - a function computing the count width from DEPTH
- One natural sub-module: dffsr_pipe_stage.
  - One stage: valid bit plus WIDTH data register, load/hold, async reset to RST_VAL.
  - The top instantiates DEPTH of them with a generate loop and holds the advance chain plus count.

Test Plan:
- Reset: R=0 with in_valid=1 → out_valid=0, out_data=RST_VAL (e.g. 8'hA5), count=0. Release R, drive 8'h11 → out_valid=1 with 8'h11 exactly 3 cycles later.
- Streaming: out_ready=1, push 8'h01..8'h0A back-to-back → same order on outputs, cycles 3..12, no gaps, in_ready always 1.
- Backpressure: out_ready=0, push 4 words → first 3 accepted, count=3, in_ready=0 on the 4th. Raise out_ready → 8'h01, 8'h02, 8'h03, 8'h04 in order, none dropped.
- Full pass-through: count=3, in_valid=1 and out_ready=1 for 5 cycles → count stays 3, one word out per cycle.
- Flush: count=2, assert flush with in_valid=1 → in_ready=0, next cycle count=0 and out_valid=0. The following push emerges after 3 cycles.
- Mid-stream reset: assert R=0 between edges while count=2 → out_valid and count fall immediately. With DFFSR_PIPE_CLK2Q_DELAY_EN defined, out_data changes 6 ns after the clock edge in the streaming test.
